mod_n_ctr: RTL and testbench

//   Free-running synchronous modulo-N up-counter: 0, 1, ..., N-1, 0, ...

---
 rtl/ctr_pkg.sv | 11 +
 rtl/mod_n_ctr.sv | 51 +++++
 tb/tb_mod_n_ctr.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ctr_pkg.sv
// Shared helpers for the modulo-N counter.
//   safe_clog2(n) : ceil(log2(n)), clamped to at least 1. A modulus of 1
//                   still needs a one-bit register, so the clamp keeps
//                   the width legal.
package ctr_pkg;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_n_ctr.sv
// Free-running modulo-N up-counter: 0, 1, ..., N-1, 0, ...
// Timebase / sequence-index source (slot counters, divider phases).
// Ports:
//   clk   : clock, all updates on the rising edge
//   rst   : synchronous reset, active low (0 = reset)
//   count : registered count value, WIDTH bits
module mod_n_ctr
  import ctr_pkg::*;
#(
  parameter int N     = 16,
  parameter int WIDTH = safe_clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count
);

  // Reject moduli that cannot be represented or make no sense.
  if (N < 1 || (WIDTH < 31 && (2 ** WIDTH) < N)) begin : g_bad_param
    $fatal(1, "mod_n_ctr: illegal parameters N=%0d WIDTH=%0d", N, WIDTH);
  end

  localparam logic [WIDTH-1:0] TERM = WIDTH'(N - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_term;
  logic             illegal;

  assign at_term = (count_q == TERM);

  // Codes above N-1 only exist when N is not a power of two; they are
  // unreachable in normal operation but are flushed to 0 in one cycle.
  if (WIDTH < 31 && N < (2 ** WIDTH)) begin : g_illegal
    assign illegal = (count_q > TERM);
  end else begin : g_no_illegal
    assign illegal = 1'b0;
  end

  // Wrap by explicit compare, never by natural overflow.
  assign count_d = (at_term || illegal) ? '0 : count_q + ONE;

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: tb/tb_mod_n_ctr.sv
// Self-checking bench for mod_n_ctr. Four instances (N=16, 10, 1, 5) run
// side by side; each is checked every cycle against a modulo-arithmetic
// reference model.
module tb_mod_n_ctr;

  logic clk = 1'b0;
  logic rst16, rst10, rst1, rst5;
  logic [3:0] c16, c10;
  logic [0:0] c1;
  logic [2:0] c5;

  int tests = 0;
  int fails = 0;
  int e16 = 0, e10 = 0, e1 = 0, e5 = 0;

  always #5 clk = ~clk;

  mod_n_ctr #(.N(16))             u16 (.clk(clk), .rst(rst16), .count(c16));
  mod_n_ctr #(.N(10), .WIDTH(4))  u10 (.clk(clk), .rst(rst10), .count(c10));
  mod_n_ctr #(.N(1))              u1  (.clk(clk), .rst(rst1),  .count(c1));
  mod_n_ctr #(.N(5),  .WIDTH(3))  u5  (.clk(clk), .rst(rst5),  .count(c5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model update uses the reset levels present at the rising edge.
  task automatic model_edge();
    e16 = rst16 ? (e16 + 1) % 16 : 0;
    e10 = rst10 ? (e10 + 1) % 10 : 0;
    e1  = rst1  ? (e1  + 1) % 1  : 0;
    e5  = rst5  ? (e5  + 1) % 5  : 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_n16"}, 32'(c16), 32'(e16));
    chk({tag, "_n10"}, 32'(c10), 32'(e10));
    chk({tag, "_n1"},  32'(c1),  32'(e1));
    chk({tag, "_n5"},  32'(c5),  32'(e5));
  endtask

  // One cycle: edge, model, then sample at the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  // Cycles between two successive N-1 values of an instance, bounded.
  task automatic measure_period(input int which, input int n, input string tag);
    int cyc;
    int seen;
    seen = 0;
    cyc  = 0;
    for (int i = 0; i < 4 * n + 4 && seen < 2; i++) begin
      step(tag);
      if (seen == 1) cyc++;
      if ((which == 10 && c10 == 4'(n - 1)) || (which == 5 && c5 == 3'(n - 1)))
        seen++;
    end
    chk({tag, "_found"}, 32'(seen), 32'd2);
    chk({tag, "_period"}, 32'(cyc), 32'(n));
  endtask

  initial begin
    rst16 = 1'b0; rst10 = 1'b0; rst1 = 1'b0; rst5 = 1'b0;

    // Reset held for two edges.
    step("reset0");
    step("reset1");
    chk("reset_c16_zero", 32'(c16), 32'd0);

    // Release: 0 -> 1 on first edge, full N=16 sequence plus wrap.
    rst16 = 1'b1; rst10 = 1'b1; rst1 = 1'b1; rst5 = 1'b1;
    for (int i = 0; i < 17; i++) step("seq");
    chk("seq_end_c16", 32'(c16), 32'd1);

    // Single-edge reset at count 7.
    for (int i = 0; i < 40 && e16 != 7; i++) step("to7");
    chk("at7", 32'(c16), 32'd7);
    rst16 = 1'b0;
    step("mid_reset");
    chk("mid_reset_zero", 32'(c16), 32'd0);
    rst16 = 1'b1;
    for (int i = 0; i < 3; i++) step("after_mid_reset");

    // Reset glitch between edges must be ignored.
    for (int i = 0; i < 40 && e16 != 4; i++) step("to4");
    @(posedge clk);
    model_edge();
    #2 rst16 = 1'b0;
    #2 rst16 = 1'b1;
    @(negedge clk);
    check_all("glitch");
    chk("glitch_c16_5", 32'(c16), 32'd5);

    // N=10 and N=5 periods, N=1 stays zero throughout (checked each step).
    for (int i = 0; i < 25; i++) step("run25");
    measure_period(10, 10, "p10");
    measure_period(5, 5, "p5");

    // Reset coinciding with terminal count.
    for (int i = 0; i < 40 && e16 != 15; i++) step("to15");
    chk("at15", 32'(c16), 32'd15);
    rst16 = 1'b0;
    step("rst_at_term");
    chk("rst_at_term_zero", 32'(c16), 32'd0);
    rst16 = 1'b1;
    step("after_term_rst");
    chk("after_term_rst_one", 32'(c16), 32'd1);

    // Random reset activity on all instances.
    for (int i = 0; i < 400; i++) begin
      rst16 = ($urandom_range(0, 15) != 0);
      rst10 = ($urandom_range(0, 15) != 0);
      rst1  = ($urandom_range(0, 3)  != 0);
      rst5  = ($urandom_range(0, 15) != 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
